// File: rtl/axi_rd_arb_pkg.sv
// Shared AR-channel constants, state encoding and size mapping
// for the two-port AXI read arbiter.
package cpu_axi_pkg;

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_AR_WAIT = 1'b1;

   localparam logic [3:0] ID_INST_DEF = 4'd0;
   localparam logic [3:0] ID_DATA_DEF = 4'd1;

   localparam logic [7:0] AR_LEN   = 8'd0;
   localparam logic [1:0] AR_BURST = 2'b01;
   localparam logic [1:0] AR_LOCK  = 2'b00;
   localparam logic [3:0] AR_CACHE = 4'b0000;
   localparam logic [2:0] AR_PROT  = 3'b000;

   function automatic logic [2:0] size_to_arsize(input logic [1:0] s);
      return {1'b0, s};
   endfunction

endpackage

// File: rtl/axi_rd_arb_if.sv
// AXI read address and read data channels shared by the
// arbiter (master) and the memory side (slave).
interface axi_rd_arb_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst,
      output arlock, arcache, arprot, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst,
      input  arlock, arcache, arprot, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_arb_outs_cnt.sv
// Saturating per-requester outstanding-read counter (never
// exceeds MAX, never wraps below zero).
module rd_outs_cnt #(
   parameter int MAX = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic at_max,
   output logic busy
);
   localparam logic [2:0] LIM = 3'(MAX);

   logic [2:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 3'd0;
      end else if (inc && !dec && cnt < LIM) begin
         cnt <= cnt + 3'd1;
      end else if (dec && !inc && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
      end
   end

   assign at_max = (cnt >= LIM);
   assign busy   = (cnt != 3'd0);
endmodule

// File: rtl/axi_rd_arb.sv
// Two-port (inst/data) AXI read arbiter, single-beat reads.
// Define AXI_RD_ROUND_ROBIN_EN for round-robin instead of data-first.
module axi_rd_arb
   import cpu_axi_pkg::*;
#(
   parameter int         OUTS_MAX = 2,
   parameter logic [3:0] ID_INST  = ID_INST_DEF,
   parameter logic [3:0] ID_DATA  = ID_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic [1:0]  inst_size,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [31:0] data_addr,
   input  logic [1:0]  data_size,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   input  logic        wr_pending,
   axi_rd_arb_if.master ax
);
   logic [0:0]  state;
   logic [3:0]  lat_id;
   logic [31:0] lat_addr;
   logic [1:0]  lat_size;
   logic        lat_data;

   logic inst_max, data_max;
   logic inst_busy, data_busy;
   logic inst_elig, data_elig;
   logic pick_data, grant, hs;
   logic rbeat, hit_inst, hit_data;
   logic unused_ok;

   assign inst_elig = inst_req & ~inst_max;
   assign data_elig = data_req & ~data_max & ~wr_pending;
   assign grant     = (state == S_IDLE) & (inst_elig | data_elig);
   assign hs        = (state == S_AR_WAIT) & ax.arready;

`ifdef AXI_RD_ROUND_ROBIN_EN
   logic last_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_data <= 1'b0;
      end else if (grant) begin
         last_data <= pick_data;
      end
   end

   assign pick_data = data_elig & (~inst_elig | ~last_data);
`else
   assign pick_data = data_elig;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         lat_id   <= 4'd0;
         lat_addr <= 32'd0;
         lat_size <= 2'd0;
         lat_data <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (grant) begin
                  state    <= S_AR_WAIT;
                  lat_data <= pick_data;
                  lat_id   <= pick_data ? ID_DATA : ID_INST;
                  lat_addr <= pick_data ? data_addr : inst_addr;
                  lat_size <= pick_data ? data_size : inst_size;
               end
            end
            S_AR_WAIT: begin
               if (ax.arready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ax.arid    = lat_id;
   assign ax.araddr  = lat_addr;
   assign ax.arsize  = size_to_arsize(lat_size);
   assign ax.arlen   = AR_LEN;
   assign ax.arburst = AR_BURST;
   assign ax.arlock  = AR_LOCK;
   assign ax.arcache = AR_CACHE;
   assign ax.arprot  = AR_PROT;
   assign ax.arvalid = (state == S_AR_WAIT);

   assign inst_addr_ok = hs & ~lat_data;
   assign data_addr_ok = hs & lat_data;

   // Beats are only accepted while something is outstanding
   assign ax.rready = inst_busy | data_busy;
   assign rbeat     = ax.rvalid & ax.rready;
   assign hit_data  = rbeat & (ax.rid == ID_DATA);
   assign hit_inst  = rbeat & (ax.rid == ID_INST) & ~hit_data;

   assign inst_data_ok = hit_inst;
   assign data_data_ok = hit_data;
   assign inst_rdata   = ax.rdata;
   assign data_rdata   = ax.rdata;

   assign unused_ok = ^{ax.rresp, ax.rlast};

   rd_outs_cnt #(.MAX(OUTS_MAX)) u_inst_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inst_addr_ok),
      .dec    (hit_inst),
      .at_max (inst_max),
      .busy   (inst_busy)
   );

   rd_outs_cnt #(.MAX(OUTS_MAX)) u_data_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (data_addr_ok),
      .dec    (hit_data),
      .at_max (data_max),
      .busy   (data_busy)
   );
endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: arbitration order, outstanding
// limit, write blocking, AR stability and reset behaviour.
module tb_axi_rd_arb;
   import cpu_axi_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, data_req, wr_pending;
   logic [31:0] inst_addr, data_addr;
   logic [1:0]  inst_size, data_size;
   logic        inst_addr_ok, inst_data_ok;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;

   int total = 0;
   int bad   = 0;
   int hs_cnt = 0;
   int base;

   axi_rd_arb_if ax ();

   axi_rd_arb dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_size    (inst_size),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_addr    (data_addr),
      .data_size    (data_size),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .wr_pending   (wr_pending),
      .ax           (ax)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (ax.arvalid && ax.arready) hs_cnt++;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clr_inputs();
      inst_req   = 1'b0;
      data_req   = 1'b0;
      wr_pending = 1'b0;
      inst_addr  = 32'd0;
      data_addr  = 32'd0;
      inst_size  = 2'd2;
      data_size  = 2'd2;
      ax.arready = 1'b0;
      ax.rvalid  = 1'b0;
      ax.rid     = 4'd0;
      ax.rdata   = 32'd0;
      ax.rresp   = 2'b00;
      ax.rlast   = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clr_inputs();
      ax.rvalid = 1'b1;
      tick();
      check("rst_arvalid", 64'(ax.arvalid), 64'd0);
      check("rst_rready", 64'(ax.rready), 64'd0);
      check("rst_dok", 64'({inst_data_ok, data_data_ok}), 64'd0);
      check("rst_aok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);

      // Simultaneous request: data first, inst two cycles later
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h1c00_0000;
      data_req = 1'b1; data_addr = 32'h0000_1000;
      ax.arready = 1'b1;
      tick();
      check("p1_arid", 64'(ax.arid), 64'd1);
      check("p1_araddr", 64'(ax.araddr), 64'h1000);
      check("p1_aok", 64'({data_addr_ok, inst_addr_ok}), 64'b10);
      check("p1_const", 64'({ax.arlen, ax.arburst, ax.arlock,
            ax.arcache, ax.arprot}), 64'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
      check("p1_arsize", 64'(ax.arsize), 64'd2);
      data_req = 1'b0;
      tick();
      check("p1_gap", 64'({ax.arvalid, inst_addr_ok}), 64'd0);
      tick();
      check("p1_arid2", 64'(ax.arid), 64'd0);
      check("p1_araddr2", 64'(ax.araddr), 64'h1c00_0000);
      check("p1_aok2", 64'({data_addr_ok, inst_addr_ok}), 64'b01);
      inst_req = 1'b0;

      // Contention right after a data grant
      do_reset();
      ax.arready = 1'b1;
      data_req = 1'b1; data_addr = 32'h2000;
      tick();
      check("p2_first", 64'(data_addr_ok), 64'd1);
      inst_req = 1'b1; inst_addr = 32'h3000;
      tick();
      tick();
`ifdef AXI_RD_ROUND_ROBIN_EN
      check("p2_arid", 64'(ax.arid), 64'd0);
      check("p2_aok", 64'({data_addr_ok, inst_addr_ok}), 64'b01);
`else
      check("p2_arid", 64'(ax.arid), 64'd1);
      check("p2_aok", 64'({data_addr_ok, inst_addr_ok}), 64'b10);
`endif
      inst_req = 1'b0; data_req = 1'b0;

      // Outstanding limit of 2 for inst reads
      do_reset();
      base = hs_cnt;
      ax.arready = 1'b1;
      inst_req = 1'b1; inst_addr = 32'h100;
      tick();
      check("p3_aok1", 64'(inst_addr_ok), 64'd1);
      tick();
      tick();
      check("p3_aok2", 64'(inst_addr_ok), 64'd1);
      tick();
      check("p3_rready", 64'(ax.rready), 64'd1);
      tick();
      check("p3_held", 64'({ax.arvalid, inst_addr_ok}), 64'd0);
      tick();
      check("p3_held2", 64'({ax.arvalid, inst_addr_ok}), 64'd0);
      check("p3_ars", 64'(hs_cnt - base), 64'd2);
      ax.rvalid = 1'b1; ax.rid = 4'd0;
      ax.rdata = 32'h0280_0000; ax.rresp = 2'b10;
      #1;
      check("p3_dok", 64'({inst_data_ok, data_data_ok}), 64'b10);
      check("p3_rdata", 64'(inst_rdata), 64'h0280_0000);
      tick();
      ax.rvalid = 1'b0;
      tick();
      check("p3_aok3", 64'({ax.arvalid, inst_addr_ok}), 64'b11);
      inst_req = 1'b0;
      tick();
      check("p3_ars3", 64'(hs_cnt - base), 64'd3);

      // Data read blocked while a write is pending
      do_reset();
      ax.arready = 1'b1;
      wr_pending = 1'b1;
      data_req = 1'b1; data_addr = 32'h3000;
      inst_req = 1'b1; inst_addr = 32'h4000;
      tick();
      check("p4_inst", 64'({inst_addr_ok, data_addr_ok}), 64'b10);
      inst_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("p4_block", 64'({ax.arvalid, data_addr_ok}), 64'd0);
      end
      wr_pending = 1'b0;
      tick();
      check("p4_go", 64'({ax.arvalid, data_addr_ok}), 64'b11);
      check("p4_arid", 64'(ax.arid), 64'd1);
      data_req = 1'b0;

      // AR stays stable while arready is low
      do_reset();
      base = hs_cnt;
      inst_req = 1'b1; inst_addr = 32'h5000;
      tick();
      inst_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("p5_stable", 64'({ax.arvalid, ax.arid, ax.araddr,
               inst_addr_ok}), 64'({1'b1, 4'd0, 32'h5000, 1'b0}));
         if (i < 3) tick();
      end
      ax.arready = 1'b1;
      #1;
      check("p5_aok", 64'(inst_addr_ok), 64'd1);
      tick();
      check("p5_done", 64'({ax.arvalid, inst_addr_ok}), 64'd0);
      check("p5_ars", 64'(hs_cnt - base), 64'd1);

      // Unknown rid dropped, known rid returned
      do_reset();
      ax.arready = 1'b1;
      data_req = 1'b1; data_addr = 32'h7000;
      tick();
      data_req = 1'b0;
      tick();
      ax.rvalid = 1'b1; ax.rid = 4'd5; ax.rdata = 32'hdead_beef;
      #1;
      check("p6_unk", 64'({inst_data_ok, data_data_ok}), 64'd0);
      tick();
      check("p6_keep", 64'(ax.rready), 64'd1);
      ax.rid = 4'd1; ax.rdata = 32'h1234_5678;
      #1;
      check("p6_dok", 64'({inst_data_ok, data_data_ok}), 64'b01);
      check("p6_rdata", 64'(data_rdata), 64'h1234_5678);
      tick();
      ax.rvalid = 1'b0;
      check("p6_idle", 64'(ax.rready), 64'd0);

      // Reset with two reads outstanding
      do_reset();
      ax.arready = 1'b1;
      inst_req = 1'b1; inst_addr = 32'h6000;
      repeat (4) tick();
      inst_req = 1'b0;
      check("p7_busy", 64'(ax.rready), 64'd1);
      rst = 1'b1;
      #1;
      check("p7_rst", 64'({ax.rready, ax.arvalid}), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      ax.rvalid = 1'b1; ax.rid = 4'd0; ax.rdata = 32'h0280_0000;
      #1;
      check("p7_drop", 64'({ax.rready, inst_data_ok}), 64'd0);
      tick();
      tick();
      check("p7_zero", 64'({ax.rready, inst_data_ok,
            ax.arvalid}), 64'd0);
      ax.rvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
